// File: rtl/rx_shift_register.sv
// rx_shift_register: UART-style serial receiver (start, 8 data bits MSB first, stop).
// Synchronises the line, samples each bit mid-period, checks framing and
// hands the byte to the consumer with a valid/ack handshake.
module rx_shift_register #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_sr_in,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       rx_frame_err,
    output logic       rx_overrun
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CW       = $clog2(CLKS_PER_BIT);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    logic          r_meta;
    logic          r_sync;
    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;

    logic w_rx_s;
    logic w_half_done;
    logic w_bit_done;

    assign w_rx_s      = r_sync;
    // Start sample lands HALF_BIT edges after the start edge; later samples are a full bit apart.
    assign w_half_done = (r_cnt == CW'(HALF_BIT - 1));
    assign w_bit_done  = (r_cnt == CW'(CLKS_PER_BIT - 1));
    assign rx_busy     = (r_state != S_IDLE);

    // Two-flop synchroniser; resets to the idle-high line level so reset never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= rx_sr_in;
            r_sync <= r_meta;
        end
    end

    // Receive FSM with bit/cycle counters, output register and handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
        end else begin
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
            // A good-frame completion below takes priority over the ack clear.
            if (rx_ack)
                rx_valid <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (!w_rx_s)
                        r_state <= S_START;
                end
                S_START: begin
                    if (w_half_done) begin
                        r_cnt <= '0;
                        if (!w_rx_s) begin
                            r_state <= S_DATA;
                            r_bit   <= 3'd0;
                        end else begin
                            // Line went back high: glitch, drop it silently.
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (w_bit_done) begin
                        r_cnt   <= '0;
                        r_shift <= {r_shift[6:0], w_rx_s};
                        if (r_bit == 3'd7)
                            r_state <= S_STOP;
                        else
                            r_bit <= r_bit + 3'd1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (w_bit_done) begin
                        r_cnt <= '0;
                        if (w_rx_s) begin
                            rx_data    <= r_shift;
                            rx_valid   <= 1'b1;
                            rx_overrun <= rx_valid && !rx_ack;
                            r_state    <= S_IDLE;
                        end else begin
                            rx_frame_err <= 1'b1;
                            r_state      <= S_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_BREAK: begin
                    // Held-low line must return high before a new start is accepted.
                    if (w_rx_s)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_shift_register.sv
// Directed bench for rx_shift_register: frames are driven at 16 clk/bit and
// outputs are sampled 1ns after the rising edge (pulse monitor on the falling edge).
module tb_rx_shift_register;

    logic       clk;
    logic       reset;
    logic       rx_sr_in;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       rx_frame_err;
    logic       rx_overrun;

    rx_shift_register #(.CLKS_PER_BIT(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_sr_in     (rx_sr_in),
        .rx_ack       (rx_ack),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_busy      (rx_busy),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: after rising edge N (and NBA) cyc == N.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor on the falling edge.
    int   err_n = 0, ovr_n = 0;
    int   err_cyc = -1, valid_cyc = -1, rise_cyc = -1, fall_cyc = -1;
    logic prev_busy = 1'b0, prev_valid = 1'b0;
    always @(negedge clk) begin
        if (rx_frame_err) begin err_n++; err_cyc = cyc; end
        if (rx_overrun) ovr_n++;
        if (rx_busy && !prev_busy) rise_cyc = cyc;
        if (!rx_busy && prev_busy) fall_cyc = cyc;
        if (rx_valid && !prev_valid) valid_cyc = cyc;
        prev_busy  = rx_busy;
        prev_valid = rx_valid;
    end

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Caller must be 1ns after a rising edge; e0 is that edge index.
    // Drives start, data MSB first, stop; returns 1ns after edge e0+160.
    task automatic send_frame(input logic [7:0] b, input logic stop, output int e0);
        logic [9:0] f;
        f  = {1'b0, b, stop};
        e0 = cyc;
        for (int k = 9; k >= 0; k--) begin
            rx_sr_in = f[k];
            repeat (16) @(posedge clk);
            #1;
        end
    endtask

    task automatic ack_pulse();
        rx_ack = 1'b1;
        @(posedge clk); #1;
        rx_ack = 1'b0;
    endtask

    int e0, e1, e2, e3, eb, ob;
    logic [7:0] exp_b2b [3];

    initial begin
        reset = 1'b1; rx_sr_in = 1'b1; rx_ack = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("rst_data", rx_data, 8'h00);
        chk("rst_valid", rx_valid, 0);
        chk("rst_busy", rx_busy, 0);
        chk("rst_err", rx_frame_err, 0);
        chk("rst_ovr", rx_overrun, 0);
        reset = 1'b0;
        repeat (4) @(posedge clk); #1;

        // Good frame 0xA5: start edge D = e0+3, completion at D+152.
        send_frame(8'hA5, 1'b1, e0);
        chk("a5_data", rx_data, 8'hA5);
        chk("a5_valid", rx_valid, 1);
        chk("a5_valid_cyc", valid_cyc, e0 + 155);
        chk("a5_busy_rise", rise_cyc, e0 + 3);
        chk("a5_busy_fall", fall_cyc, e0 + 155);
        chk("a5_no_err", err_n, 0);
        chk("a5_no_ovr", ovr_n, 0);
        ack_pulse();
        chk("a5_ack_clr", rx_valid, 0);
        repeat (3) @(posedge clk); #1;

        // False start: 5 cycles low, glitch rejected at D+8.
        e1 = cyc;
        rx_sr_in = 1'b0;
        repeat (5) @(posedge clk); #1;
        rx_sr_in = 1'b1;
        repeat (15) @(posedge clk); #1;
        chk("fs_busy_rise", rise_cyc, e1 + 3);
        chk("fs_busy_fall", fall_cyc, e1 + 11);
        chk("fs_busy", rx_busy, 0);
        chk("fs_valid", rx_valid, 0);
        chk("fs_no_err", err_n, 0);

        // Framing error: 0x3C with stop = 0, then line held low 40 more cycles.
        send_frame(8'h3C, 1'b0, e2);
        chk("fe_cnt", err_n, 1);
        chk("fe_cyc", err_cyc, e2 + 155);
        chk("fe_data_kept", rx_data, 8'hA5);
        chk("fe_valid", rx_valid, 0);
        chk("fe_busy_break", rx_busy, 1);
        repeat (40) @(posedge clk); #1;
        chk("fe_still_break", rx_busy, 1);
        chk("fe_no_retrig", err_n, 1);
        rx_sr_in = 1'b1;
        repeat (4) @(posedge clk); #1;
        chk("fe_idle", rx_busy, 0);
        repeat (4) @(posedge clk); #1;

        // Overrun: 0x11 then 0x22 back-to-back, no ack.
        ob = ovr_n;
        send_frame(8'h11, 1'b1, e3);
        send_frame(8'h22, 1'b1, e3);
        repeat (3) @(posedge clk); #1;
        chk("ov_data", rx_data, 8'h22);
        chk("ov_valid", rx_valid, 1);
        chk("ov_pulse", ovr_n - ob, 1);
        ack_pulse();
        chk("ov_ack_clr", rx_valid, 0);
        repeat (3) @(posedge clk); #1;

        // Same, but ack lands on the second completion edge (e3+315).
        ob = ovr_n;
        fork
            begin
                send_frame(8'h5A, 1'b1, e3);
                send_frame(8'hC3, 1'b1, eb);
            end
            begin
                repeat (314) @(posedge clk); #1;
                rx_ack = 1'b1;
                @(posedge clk); #1;
                rx_ack = 1'b0;
            end
        join
        repeat (2) @(posedge clk); #1;
        chk("hs_data", rx_data, 8'hC3);
        chk("hs_valid", rx_valid, 1);
        chk("hs_no_ovr", ovr_n - ob, 0);
        ack_pulse();
        repeat (3) @(posedge clk); #1;

        // Zero-gap back-to-back frames with a consumer acking each byte.
        exp_b2b[0] = 8'hFF; exp_b2b[1] = 8'h00; exp_b2b[2] = 8'h80;
        ob = ovr_n;
        eb = err_n;
        fork
            begin
                send_frame(8'hFF, 1'b1, e3);
                send_frame(8'h00, 1'b1, e3);
                send_frame(8'h80, 1'b1, e3);
            end
            begin
                for (int j = 0; j < 3; j++) begin
                    int w;
                    w = 0;
                    while (!rx_valid && w < 400) begin
                        @(posedge clk); #1;
                        w++;
                    end
                    chk("b2b_timeout", (w < 400), 1);
                    chk("b2b_data", rx_data, exp_b2b[j]);
                    ack_pulse();
                end
            end
        join
        repeat (3) @(posedge clk); #1;
        chk("b2b_no_ovr", ovr_n - ob, 0);
        chk("b2b_no_err", err_n - eb, 0);
        chk("b2b_valid_clr", rx_valid, 0);

        // Async reset mid-DATA, asserted between clock edges.
        ob = ovr_n;
        eb = err_n;
        rx_sr_in = 1'b0;
        repeat (30) @(posedge clk); #1;
        chk("mr_busy_pre", rx_busy, 1);
        #3 reset = 1'b1;
        #1;
        chk("mr_data", rx_data, 8'h00);
        chk("mr_busy", rx_busy, 0);
        chk("mr_valid", rx_valid, 0);
        rx_sr_in = 1'b1;
        repeat (3) @(posedge clk); #1;
        reset = 1'b0;
        repeat (40) @(posedge clk); #1;
        chk("mr_idle_valid", rx_valid, 0);
        chk("mr_idle_busy", rx_busy, 0);
        chk("mr_no_pulses", (ovr_n - ob) + (err_n - eb), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rx_shift_register.md
Name: rx_shift_register

Overview:
Serial-to-parallel receiver for the 10-bit UART-style frame produced by the transmit shift register. Frame bits go out frame bit 9 first, and the line idles high:
- start bit (0)
- data[7] down to data[0]
- stop bit (1)

The block synchronises the line, detects the start edge and samples each bit at mid-period. It checks framing, then presents the byte with a valid/ack handshake to the downstream consumer.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit; even, >= 4
HALF_BIT, CLKS_PER_BIT/2, cycles from start-edge detection to the start-bit sample (derived, not overridden)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
rx_sr_in  input  1  serial line, asynchronous to clk, idle high
rx_ack  input  1  consumer has taken rx_data; clears rx_valid
rx_data  output  8  last correctly framed byte, held until next good frame
rx_valid  output  1  level: rx_data holds an unconsumed byte
rx_busy  output  1  high while the FSM is outside IDLE
rx_frame_err  output  1  1-cycle pulse: stop bit sampled as 0
rx_overrun  output  1  1-cycle pulse: good frame completed while rx_valid already high and no rx_ack that cycle

Behaviour:
- Reset (async, active-high):
  - Sync flops = 1; FSM = IDLE; bit counter and cycle counter = 0.
  - rx_data = 0; rx_valid = rx_busy = rx_frame_err = rx_overrun = 0.
  - Reset mid-frame aborts the frame with no output pulses.
- Synchroniser: 2 flops on rx_sr_in, then the FSM reads rx_s. Line change before edge E is visible to the FSM at edge E+2.
- FSM states:
  - IDLE: rx_s==0 at edge D → START, cycle counter cleared.
  - START: at D+HALF_BIT, sample rx_s.
    - 0 → DATA, bit counter = 0.
    - 1 → IDLE (glitch/false start; no pulses).
  - DATA: sample every CLKS_PER_BIT cycles. Data bit i (i=0..7, i=0 is data[7]) is sampled at D+HALF_BIT+(i+1)*CLKS_PER_BIT.
    - Shift register shifts left, LSB in, giving MSB-first assembly.
    - After the 8th sample → STOP.
  - STOP: sample at D+HALF_BIT+9*CLKS_PER_BIT.
    - rx_s==1 → rx_data <= shift reg, rx_valid <= 1; overrun check; → IDLE.
    - rx_s==0 → rx_frame_err pulse; rx_data and rx_valid unchanged; → BREAK.
  - BREAK: wait for rx_s==1, then → IDLE. A held-low line never retriggers.
- Outputs update on the same edge as the stop sample. IDLE can detect a new start on the very next edge, so back-to-back frames need no gap.
- rx_busy = 1 in START, DATA, STOP and BREAK.
- Handshake, on a good-frame completion edge:
  - rx_ack=1 at the same time → rx_valid stays 1 and takes the new data, no overrun.
  - rx_valid=1 and rx_ack=0 → rx_data overwritten, rx_valid stays 1, rx_overrun pulses.
  - rx_ack with rx_valid=0 → no effect.
- Counters:
  - Cycle counter width = clog2(CLKS_PER_BIT); wraps to 0 on each sample.
  - Bit counter is 3 bits.
  - No arithmetic overflow is possible within a frame.

Test Plan:
- Reset: assert reset mid-DATA for 3 cycles, async to clk → all outputs 0 immediately; after release, an idle-high line gives no rx_valid.
- Good frame, CLKS_PER_BIT=16: send 0xA5 as 0,1,0,1,0,0,1,0,1,1 at 16 cycles/bit.
  - rx_data=0xA5 and rx_valid=1 appear at D+152.
  - rx_busy is high D..D+151.
  - No err or overrun pulses.
- False start: drive line low 5 cycles then high → back in IDLE at D+8, rx_busy low, no pulses.
- Framing error: send 0x3C with stop bit 0, then hold low 40 cycles, then high → rx_frame_err one pulse at D+152; rx_data retains the previous value; no new frame until the line returns high.
- Overrun/handshake: two back-to-back frames 0x11 then 0x22 with rx_ack never asserted → rx_data=0x22, one rx_overrun pulse. Repeat with rx_ack=1 on the second completion edge → no overrun, rx_valid=1.
- Back-to-back, 0-cycle gap: frames 0xFF, 0x00, 0x80 → three rx_valid/ack cycles with the correct bytes and no errors.
